mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// M-stage load/store sequencer: checks the address at accept, runs one bus
// transaction with a bounded wait, and returns the extended load result.
module mem_access_unit #(
  parameter logic [31:0] DM_TOP       = 32'h0000_2FFF,
  parameter int          N_TIMER      = 2,
  parameter logic [31:0] TIMER_BASE   = 32'h0000_7F00,
  parameter logic [31:0] TIMER_STRIDE = 32'h0000_0010,
  parameter int          TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [4:0]  exc_code,
  output logic [31:0] badvaddr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] OP_LW  = 8'd30;
  localparam logic [7:0] OP_LH  = 8'd31;
  localparam logic [7:0] OP_LHU = 8'd32;
  localparam logic [7:0] OP_LB  = 8'd33;
  localparam logic [7:0] OP_LBU = 8'd34;
  localparam logic [7:0] OP_SW  = 8'd35;
  localparam logic [7:0] OP_SH  = 8'd36;
  localparam logic [7:0] OP_SB  = 8'd37;
  localparam int         CW     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        is_mem, is_store_in, in_timer, timer_cnt_hit, misaligned, illegal, accept;
  logic [31:0] win_base;
  logic        st_q;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_data, st_wdata;
  logic [3:0]  st_byteen;

  // Timer windows are checked by full range; the count register is one word inside each.
  always_comb begin
    in_timer      = 1'b0;
    timer_cnt_hit = 1'b0;
    win_base      = TIMER_BASE;
    for (int i = 0; i < N_TIMER; i++) begin
      win_base = TIMER_BASE + TIMER_STRIDE * 32'(i);
      if (addr >= win_base && addr <= win_base + 32'hB) in_timer = 1'b1;
      if (addr == win_base + 32'h8) timer_cnt_hit = 1'b1;
    end
    is_mem      = (op >= OP_LW) && (op <= OP_SB);
    is_store_in = (op >= OP_SW) && (op <= OP_SB);
    misaligned  = (op == OP_LW && addr[1:0] != 2'b00) ||
                  ((op == OP_LH || op == OP_LHU) && addr[0]);
    illegal     = misaligned ||
                  (in_timer && op != OP_LW && op != OP_SW) ||
                  (is_store_in && timer_cnt_hit) ||
                  (addr > DM_TOP && !in_timer);
    accept      = (state_q == IDLE) && valid && is_mem && !flush;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = illegal ? ERR : REQ;
        end
      end
      REQ: begin
        // A ready in the final wait cycle still completes normally.
        if (bus_ready) begin
          word_d  = bus_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(TIMEOUT - 1)) state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    st_q    = (op_q >= OP_SW);
    ld_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
    ld_byte = 8'(word_q >> {addr_q[1:0], 3'b000});
    case (op_q)
      OP_LW:   ld_data = word_q;
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0000, ld_half};
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h000000, ld_byte};
      default: ld_data = 32'h0;
    endcase
    case (op_q)
      OP_SW: begin
        st_byteen = 4'b1111;
        st_wdata  = wdata_q;
      end
      OP_SH: begin
        st_byteen = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata  = addr_q[1] ? {wdata_q[15:0], 16'h0000} : {16'h0000, wdata_q[15:0]};
      end
      OP_SB: begin
        st_byteen = 4'b0001 << addr_q[1:0];
        st_wdata  = {24'h000000, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
      end
      default: begin
        st_byteen = 4'b0000;
        st_wdata  = 32'h0;
      end
    endcase
  end

  // Outputs are forced to zero during reset and during a flush cycle's pulses.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    rdata      = 32'h0;
    exc        = 1'b0;
    exc_code   = 5'd0;
    badvaddr   = 32'h0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = 32'h0;
    bus_wdata  = 32'h0;
    bus_byteen = 4'b0000;
    if (!reset) begin
      case (state_q)
        IDLE: busy = valid && is_mem && !flush;
        REQ: begin
          busy       = !flush;
          bus_req    = !flush;
          bus_we     = st_q;
          bus_addr   = addr_q;
          bus_wdata  = st_wdata;
          bus_byteen = st_byteen;
        end
        DONE: begin
          if (!flush) begin
            done  = 1'b1;
            rdata = ld_data;
          end
        end
        ERR: begin
          if (!flush) begin
            done     = 1'b1;
            exc      = 1'b1;
            exc_code = st_q ? 5'd5 : 5'd4;
            badvaddr = addr_q;
          end
        end
        default: busy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, random
// transactions against a spec-level model, and flush/reset corner sequences.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset, valid, flush, bus_ready;
  logic [7:0]  op;
  logic [31:0] addr, wdata, bus_rdata;
  logic        busy, done, exc, bus_req, bus_we;
  logic [31:0] rdata, badvaddr, bus_addr, bus_wdata;
  logic [4:0]  exc_code;
  logic [3:0]  bus_byteen;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          delay;
    logic        exc;
    logic [4:0]  code;
    logic [3:0]  byteen;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } vec_t;

  mem_access_unit #(
    .DM_TOP(32'h0000_2FFF), .N_TIMER(2), .TIMER_BASE(32'h0000_7F00),
    .TIMER_STRIDE(32'h10), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .addr(addr), .wdata(wdata),
    .flush(flush), .busy(busy), .done(done), .rdata(rdata), .exc(exc),
    .exc_code(exc_code), .badvaddr(badvaddr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] o, input logic [31:0] a,
                               input logic [31:0] d);
    valid = v;
    op    = o;
    addr  = a;
    wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int nonzero_outputs();
    int n = 0;
    if (busy) n++;
    if (done) n++;
    if (rdata != 0) n++;
    if (exc) n++;
    if (exc_code != 0) n++;
    if (badvaddr != 0) n++;
    if (bus_req) n++;
    if (bus_we) n++;
    if (bus_addr != 0) n++;
    if (bus_wdata != 0) n++;
    if (bus_byteen != 0) n++;
    return n;
  endfunction

  // Reference model: expected result of one access from the address map and op rules.
  function automatic vec_t model(input logic [7:0] o, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int dly);
    vec_t v;
    int off;
    bit ld, st, in_t, bad;
    longint lo;
    logic [31:0] h, b;
    v.op = o; v.addr = a; v.wdata = wd; v.brdata = rd;
    ld  = (o >= 8'd30 && o <= 8'd34);
    st  = (o >= 8'd35 && o <= 8'd37);
    off = int'(a % 4);
    bad = 0; in_t = 0;
    if (o == 8'd30 && off != 0) bad = 1;
    if ((o == 8'd31 || o == 8'd32) && (off % 2) == 1) bad = 1;
    for (int i = 0; i < 2; i++) begin
      lo = 64'h7F00 + i * 16;
      if (a >= lo && a <= lo + 11) begin
        in_t = 1;
        if (o != 8'd30 && o != 8'd35) bad = 1;
        if (st && a == lo + 8) bad = 1;
      end
    end
    if (a > 32'h2FFF && !in_t) bad = 1;
    v.byteen = 4'h0; v.bwdata = 32'h0; v.rdata = 32'h0;
    case (o)
      8'd35: begin v.byteen = 4'hF; v.bwdata = wd; end
      8'd36: begin v.byteen = (off >= 2) ? 4'hC : 4'h3; v.bwdata = (wd & 32'hFFFF) << (16 * (off / 2)); end
      8'd37: begin v.byteen = 4'(1 << off); v.bwdata = (wd & 32'hFF) << (8 * off); end
      default: ;
    endcase
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    b = (rd >> (8 * off)) & 32'hFF;
    case (o)
      8'd30: v.rdata = rd;
      8'd31: v.rdata = h[15] ? (h | 32'hFFFF_0000) : h;
      8'd32: v.rdata = h;
      8'd33: v.rdata = b[7] ? (b | 32'hFFFF_FF00) : b;
      8'd34: v.rdata = b;
      default: ;
    endcase
    v.exc   = bad || (dly >= TIMEOUT);
    v.code  = ld ? 5'd4 : 5'd5;
    v.delay = bad ? 0 : dly;
    return v;
  endfunction

  // One complete access; entered and left at 1 time unit after a rising edge.
  task automatic run_txn(input vec_t v, input string tag);
    int n_req;
    bus_rdata = v.brdata;
    bus_ready = 1'b0;
    flush     = 1'b0;
    applyStimulus(1'b1, v.op, v.addr, v.wdata);
    @(negedge clk);
    checkOutput({tag, ".busy_accept"}, 32'(busy), 32'd1);
    checkOutput({tag, ".req_accept"}, 32'(bus_req), 32'd0);
    next_cycle();
    applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
    if (v.exc && v.delay < TIMEOUT) begin
      @(negedge clk);
      checkOutput({tag, ".exc"}, 32'(exc), 32'd1);
      checkOutput({tag, ".done_err"}, 32'(done), 32'd1);
      checkOutput({tag, ".exc_code"}, 32'(exc_code), 32'(v.code));
      checkOutput({tag, ".badvaddr"}, badvaddr, v.addr);
      checkOutput({tag, ".req_err"}, 32'(bus_req), 32'd0);
      checkOutput({tag, ".busy_err"}, 32'(busy), 32'd0);
    end else begin
      n_req = (v.delay >= TIMEOUT) ? TIMEOUT : v.delay + 1;
      for (int k = 0; k < n_req; k++) begin
        bus_ready = (k == v.delay);
        @(negedge clk);
        checkOutput({tag, ".bus_req"}, 32'(bus_req), 32'd1);
        checkOutput({tag, ".bus_we"}, 32'(bus_we), 32'(v.op >= 8'd35));
        checkOutput({tag, ".bus_addr"}, bus_addr, v.addr);
        checkOutput({tag, ".byteen"}, 32'(bus_byteen), 32'(v.byteen));
        checkOutput({tag, ".bus_wdata"}, bus_wdata, v.bwdata);
        checkOutput({tag, ".done_wait"}, 32'(done), 32'd0);
        checkOutput({tag, ".busy_wait"}, 32'(busy), 32'd1);
        next_cycle();
      end
      bus_ready = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".done"}, 32'(done), 32'd1);
      checkOutput({tag, ".req_end"}, 32'(bus_req), 32'd0);
      checkOutput({tag, ".busy_end"}, 32'(busy), 32'd0);
      if (v.exc) begin
        checkOutput({tag, ".exc_to"}, 32'(exc), 32'd1);
        checkOutput({tag, ".exc_code_to"}, 32'(exc_code), 32'(v.code));
        checkOutput({tag, ".badvaddr_to"}, badvaddr, v.addr);
      end else begin
        checkOutput({tag, ".exc_ok"}, 32'(exc), 32'd0);
        checkOutput({tag, ".rdata"}, rdata, v.rdata);
      end
    end
    next_cycle();
    @(negedge clk);
    checkOutput({tag, ".done_once"}, 32'(done), 32'd0);
    checkOutput({tag, ".exc_once"}, 32'(exc), 32'd0);
    next_cycle();
  endtask

  vec_t tbl[15];
  vec_t rv;

  initial begin
    // Directed vectors: {op, addr, wdata, bus_rdata, ready delay, exc, code, byteen, bus_wdata, rdata}
    tbl[0]  = '{8'd33, 32'h1003, 32'h0,       32'h80FF_FF7F, 0,  1'b0, 5'd0, 4'h0, 32'h0,       32'hFFFF_FF80};
    tbl[1]  = '{8'd36, 32'h0002, 32'h0000_ABCD, 32'h0,       3,  1'b0, 5'd0, 4'hC, 32'hABCD_0000, 32'h0};
    tbl[2]  = '{8'd35, 32'h7F18, 32'h1234_5678, 32'h0,       0,  1'b1, 5'd5, 4'h0, 32'h0,       32'h0};
    tbl[3]  = '{8'd30, 32'h3000, 32'h0,       32'h0,         0,  1'b1, 5'd4, 4'h0, 32'h0,       32'h0};
    tbl[4]  = '{8'd30, 32'h0100, 32'h0,       32'h1234_5678, 15, 1'b1, 5'd4, 4'h0, 32'h0,       32'h0};
    tbl[5]  = '{8'd30, 32'h0100, 32'h0,       32'h1234_5678, 14, 1'b0, 5'd0, 4'h0, 32'h0,       32'h1234_5678};
    tbl[6]  = '{8'd32, 32'h0202, 32'h0,       32'h8001_7FFF, 1,  1'b0, 5'd0, 4'h0, 32'h0,       32'h0000_8001};
    tbl[7]  = '{8'd31, 32'h0200, 32'h0,       32'h1234_8765, 0,  1'b0, 5'd0, 4'h0, 32'h0,       32'hFFFF_8765};
    tbl[8]  = '{8'd37, 32'h0011, 32'hDEAD_BEEF, 32'h0,       2,  1'b0, 5'd0, 4'h2, 32'h0000_EF00, 32'h0};
    tbl[9]  = '{8'd31, 32'h7F00, 32'h0,       32'h0,         0,  1'b1, 5'd4, 4'h0, 32'h0,       32'h0};
    tbl[10] = '{8'd30, 32'h0002, 32'h0,       32'h0,         0,  1'b1, 5'd4, 4'h0, 32'h0,       32'h0};
    tbl[11] = '{8'd35, 32'h7F04, 32'h0000_0055, 32'h0,       0,  1'b0, 5'd0, 4'hF, 32'h0000_0055, 32'h0};
    tbl[12] = '{8'd34, 32'h2FFF, 32'h0,       32'h80FF_FF7F, 0,  1'b0, 5'd0, 4'h0, 32'h0,       32'h0000_0080};
    tbl[13] = '{8'd30, 32'h7F20, 32'h0,       32'h0,         0,  1'b1, 5'd4, 4'h0, 32'h0,       32'h0};
    tbl[14] = '{8'd37, 32'h7F1B, 32'h0,       32'h0,         0,  1'b1, 5'd5, 4'h0, 32'h0,       32'h0};

    // Reset: outputs stay zero even with a memory op presented.
    reset = 1'b1; flush = 1'b0; bus_ready = 1'b0; bus_rdata = 32'h0;
    applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    applyStimulus(1'b1, 8'd30, 32'h0100, 32'h0);
    @(negedge clk);
    checkOutput("reset.outputs", 32'(nonzero_outputs()), 32'd0);
    next_cycle();
    reset = 1'b0;
    applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post_reset.outputs", 32'(nonzero_outputs()), 32'd0);
    next_cycle();

    for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Non-memory ops at both edges of the memory op range cause nothing.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, (i == 0) ? 8'd29 : 8'd38, 32'h0100, 32'h0);
      @(negedge clk);
      checkOutput("nonmem.busy", 32'(busy), 32'd0);
      next_cycle();
      applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
      @(negedge clk);
      checkOutput("nonmem.req", 32'(bus_req), 32'd0);
      checkOutput("nonmem.done", 32'(done), 32'd0);
      next_cycle();
    end

    // Flush at accept: no access is started.
    flush = 1'b1;
    applyStimulus(1'b1, 8'd30, 32'h0100, 32'h0);
    @(negedge clk);
    checkOutput("flush_accept.busy", 32'(busy), 32'd0);
    next_cycle();
    flush = 1'b0;
    applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush_accept.req", 32'(bus_req), 32'd0);
    next_cycle();

    // Flush during REQ: request drops, no done or exception ever appears.
    applyStimulus(1'b1, 8'd30, 32'h0100, 32'h0);
    next_cycle();
    applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush_req.req_before", 32'(bus_req), 32'd1);
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_req.busy", 32'(busy), 32'd0);
    next_cycle();
    flush = 1'b0;
    bus_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("flush_req.req_after", 32'(bus_req), 32'd0);
      checkOutput("flush_req.done", 32'(done), 32'd0);
      checkOutput("flush_req.exc", 32'(exc), 32'd0);
      checkOutput("flush_req.busy_after", 32'(busy), 32'd0);
      next_cycle();
    end
    bus_ready = 1'b0;

    // Reset during REQ: everything zero during and after, no done pulse.
    applyStimulus(1'b1, 8'd35, 32'h0040, 32'h0000_0001);
    next_cycle();
    applyStimulus(1'b0, 8'd0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("reset_req.req_before", 32'(bus_req), 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_req.during", 32'(nonzero_outputs()), 32'd0);
    next_cycle();
    reset = 1'b0;
    bus_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("reset_req.after", 32'(nonzero_outputs()), 32'd0);
      next_cycle();
    end
    bus_ready = 1'b0;

    // Random accesses across DM, timer windows and unmapped space.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  ro;
      logic [31:0] ra;
      int rsel, dly;
      ro   = 8'(30 + $urandom_range(0, 7));
      rsel = $urandom_range(0, 3);
      case (rsel)
        0:       ra = 32'($urandom_range(0, 32'h2FFF));
        1:       ra = 32'h7F00 + 32'(16 * $urandom_range(0, 2)) + 32'($urandom_range(0, 15));
        2:       ra = 32'($urandom_range(32'h3000, 32'hFFFF));
        default: ra = 32'($urandom_range(0, 32'hBFF)) * 4;
      endcase
      rsel = $urandom_range(0, 9);
      dly  = (rsel < 7) ? (rsel % 4) : ((rsel == 7) ? 14 : 15 + $urandom_range(0, 3));
      rv   = model(ro, ra, $urandom, $urandom, dly);
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
